// File: rtl/des_block_packer.sv
// des_block_packer: packs a byte stream into 64-bit blocks for the 3DES input.
// First byte lands in Block_Out[63:56]. A flush pads the partial block and
// marks it last. Build option: define PKCS_PAD_EN for PKCS#5 padding (and a
// full 0x08 pad block on an aligned flush); otherwise partial blocks are
// zero-filled and an aligned flush emits nothing.
module des_block_packer #(
  parameter int COUNT_W = 16
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [7:0]         Byte_In,
  input  logic               Byte_Valid,
  output logic               Byte_Ready,
  input  logic               Flush,
  output logic [63:0]        Block_Out,
  output logic               Block_Valid,
  input  logic               Block_Ready,
  output logic               Block_Last,
  output logic [COUNT_W-1:0] Block_Count
);

  localparam int NUM_LANES = 8;

`ifdef PKCS_PAD_EN
  typedef enum logic [1:0] {S_FILL, S_HOLD, S_PAD} state_t;
`else
  typedef enum logic [1:0] {S_FILL, S_HOLD} state_t;
`endif

  state_t      state;
  logic [2:0]  k;
  logic        flush_pending;
  logic [7:0]  lane_q [NUM_LANES];
  logic [7:0]  lane_d [NUM_LANES];

  logic        accept;
  logic        svc;
  logic [3:0]  k_nxt;
  logic        pad_fill;
  logic        pad_blk;
  logic [7:0]  pad_val;

  assign Byte_Ready  = (state == S_FILL) && !flush_pending;
  assign Block_Valid = (state != S_FILL);
  assign accept      = Byte_Valid && Byte_Ready;
  // flush (new pulse or pending) is only acted on while filling, after the byte
  assign svc         = (state == S_FILL) && (flush_pending || Flush);
  assign k_nxt       = {1'b0, k} + {3'b000, accept};
  assign pad_fill    = svc && (k_nxt != 4'd0) && !k_nxt[3];

`ifdef PKCS_PAD_EN
  assign pad_val = 8'd8 - {4'd0, k_nxt};
  assign pad_blk = svc && (k_nxt == 4'd0);
`else
  assign pad_val = 8'h00;
  assign pad_blk = 1'b0;
`endif

  // per-lane next value: incoming byte, pad byte, whole-block pad, or hold
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_d[i] = (accept && (k == 3'(i)))        ? Byte_In :
                       (pad_fill && (4'(i) >= k_nxt)) ? pad_val :
                       pad_blk                         ? 8'h08   :
                                                         lane_q[i];
    assign Block_Out[63-8*i -: 8] = lane_q[i];
  end

  // lane storage; only written while filling so the held block stays stable
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_LANES; i++) lane_q[i] <= 8'h00;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) lane_q[i] <= lane_d[i];
    end
  end

  // control FSM: fill / hold / pad, flush bookkeeping, transfer counter
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state         <= S_FILL;
      k             <= 3'd0;
      flush_pending <= 1'b0;
      Block_Last    <= 1'b0;
      Block_Count   <= '0;
    end else begin
      case (state)
        S_FILL: begin
          if (svc) begin
            if (k_nxt[3]) begin
              // byte completed the block; flush now refers to an empty block
              state <= S_HOLD;
              k     <= 3'd0;
`ifdef PKCS_PAD_EN
              flush_pending <= 1'b1;  // pad block follows after this transfer
              Block_Last    <= 1'b0;
`else
              flush_pending <= 1'b0;  // nothing to pad: this block is the last
              Block_Last    <= 1'b1;
`endif
            end else if (k_nxt != 4'd0) begin
              state         <= S_HOLD;
              k             <= 3'd0;
              flush_pending <= 1'b0;
              Block_Last    <= 1'b1;
            end else begin
`ifdef PKCS_PAD_EN
              state      <= S_PAD;
              Block_Last <= 1'b1;
`endif
              flush_pending <= 1'b0;
            end
          end else if (k_nxt[3]) begin
            state <= S_HOLD;
            k     <= 3'd0;
          end else begin
            k <= k_nxt[2:0];
          end
        end
        default: begin
          // HOLD or PAD: a flush here waits for the next FILL cycle
          if (Flush) flush_pending <= 1'b1;
          if (Block_Ready) begin
            state       <= S_FILL;
            Block_Last  <= 1'b0;
            Block_Count <= Block_Count + {{(COUNT_W-1){1'b0}}, 1'b1};
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_des_block_packer.sv
// tb_des_block_packer: directed vector table plus hand sequences for
// backpressure and async reset. Expectations follow PKCS_PAD_EN if defined.
module tb_des_block_packer;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [7:0]  Byte_In = 8'h00;
  logic        Byte_Valid = 1'b0;
  logic        Byte_Ready;
  logic        Flush = 1'b0;
  logic [63:0] Block_Out;
  logic        Block_Valid;
  logic        Block_Ready = 1'b0;
  logic        Block_Last;
  logic [15:0] Block_Count;

  int checks = 0;
  int failures = 0;

  des_block_packer #(.COUNT_W(16)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Byte_In(Byte_In), .Byte_Valid(Byte_Valid),
    .Byte_Ready(Byte_Ready), .Flush(Flush), .Block_Out(Block_Out),
    .Block_Valid(Block_Valid), .Block_Ready(Block_Ready),
    .Block_Last(Block_Last), .Block_Count(Block_Count)
  );

  always #5 Clk = ~Clk;

`ifdef PKCS_PAD_EN
  localparam logic [63:0] PART   = 64'hAABBCC0505050505;
  localparam logic [15:0] C3     = 16'd4;
  localparam logic [15:0] CT     = 16'd6;
  localparam logic        SIM_LAST = 1'b0;
`else
  localparam logic [63:0] PART   = 64'hAABBCC0000000000;
  localparam logic [15:0] C3     = 16'd3;
  localparam logic [15:0] CT     = 16'd4;
  localparam logic        SIM_LAST = 1'b1;
`endif
  localparam logic [63:0] PADB = 64'h0808080808080808;

  typedef struct {
    logic [7:0]  b;
    logic        v, f, r;
    logic        e_rdy, e_vld, e_last, has_out;
    logic [63:0] e_out;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [7:0] b, input logic v, f, r,
                     input logic er, ev, el, ho, input logic [63:0] eo,
                     input logic [15:0] ec);
    vec_t t;
    t.b = b; t.v = v; t.f = f; t.r = r;
    t.e_rdy = er; t.e_vld = ev; t.e_last = el; t.has_out = ho;
    t.e_out = eo; t.e_cnt = ec;
    tbl.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic step(input logic [7:0] b, input logic v, f, r);
    @(negedge Clk);
    Byte_In = b; Byte_Valid = v; Flush = f; Block_Ready = r;
    #1;
  endtask

  task automatic expect_o(input string nm, input logic er, ev, el, ho,
                          input logic [63:0] eo, input logic [15:0] ec);
    chk({nm, ".ready"}, 64'(Byte_Ready), 64'(er));
    chk({nm, ".valid"}, 64'(Block_Valid), 64'(ev));
    chk({nm, ".last"},  64'(Block_Last), 64'(el));
    if (ho) chk({nm, ".out"}, Block_Out, eo);
    chk({nm, ".count"}, 64'(Block_Count), 64'(ec));
  endtask

  initial begin
    // reset state
    #1;
    expect_o("reset", 1'b1, 1'b0, 1'b0, 1'b1, 64'h0, 16'd0);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;

    // full block 01..08
    for (int i = 0; i < 8; i++) add(8'(i + 1), 1, 0, 1, 1, 0, 0, 0, 64'h0, 16'd0);
    add(8'h00, 0, 0, 1, 0, 1, 0, 1, 64'h0102030405060708, 16'd0);
    // partial flush
    add(8'hAA, 1, 0, 1, 1, 0, 0, 0, 64'h0, 16'd1);
    add(8'hBB, 1, 0, 1, 1, 0, 0, 0, 64'h0, 16'd1);
    add(8'hCC, 1, 0, 1, 1, 0, 0, 0, 64'h0, 16'd1);
    add(8'h00, 0, 1, 1, 1, 0, 0, 0, 64'h0, 16'd1);
    add(8'h00, 0, 0, 1, 0, 1, 1, 1, PART, 16'd1);
    // aligned flush, flush arrives while block is held
    for (int i = 0; i < 8; i++) add(8'h10 + 8'(i), 1, 0, 1, 1, 0, 0, 0, 64'h0, 16'd2);
    add(8'h00, 0, 1, 1, 0, 1, 0, 1, 64'h1011121314151617, 16'd2);
    add(8'h00, 0, 0, 1, 0, 0, 0, 0, 64'h0, 16'd3);
`ifdef PKCS_PAD_EN
    add(8'h00, 0, 0, 1, 0, 1, 1, 1, PADB, 16'd3);
`else
    add(8'h00, 0, 0, 1, 1, 0, 0, 0, 64'h0, 16'd3);
`endif
    // 8th byte together with flush
    for (int i = 0; i < 7; i++) add(8'h11 * 8'(i + 1), 1, 0, 1, 1, 0, 0, 0, 64'h0, C3);
    add(8'h55, 1, 1, 1, 1, 0, 0, 0, 64'h0, C3);
    add(8'h00, 0, 0, 1, 0, 1, SIM_LAST, 1, 64'h1122334455667755, C3);
`ifdef PKCS_PAD_EN
    add(8'h00, 0, 0, 1, 0, 0, 0, 0, 64'h0, C3 + 16'd1);
    add(8'h00, 0, 0, 1, 0, 1, 1, 1, PADB, C3 + 16'd1);
`endif
    add(8'h00, 0, 0, 1, 1, 0, 0, 0, 64'h0, CT);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].b, tbl[i].v, tbl[i].f, tbl[i].r);
      expect_o($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_vld, tbl[i].e_last,
               tbl[i].has_out, tbl[i].e_out, tbl[i].e_cnt);
    end

    // backpressure: 20 held cycles, byte offered, flush pulsed mid-hold
    for (int i = 0; i < 8; i++) begin
      step(8'hA0 + 8'(i), 1, 0, 0);
      expect_o($sformatf("bp_fill%0d", i), 1, 0, 0, 0, 64'h0, CT);
    end
    for (int j = 0; j < 20; j++) begin
      step(8'hEE, 1, (j == 5), 0);
      expect_o($sformatf("bp_hold%0d", j), 0, 1, 0, 1, 64'hA0A1A2A3A4A5A6A7, CT);
    end
    step(8'h00, 0, 0, 1);
    expect_o("bp_xfer", 0, 1, 0, 1, 64'hA0A1A2A3A4A5A6A7, CT);
    step(8'h00, 0, 0, 1);
    expect_o("bp_svc", 0, 0, 0, 0, 64'h0, CT + 16'd1);
`ifdef PKCS_PAD_EN
    step(8'h00, 0, 0, 1);
    expect_o("bp_pad", 0, 1, 1, 1, PADB, CT + 16'd1);
    step(8'h00, 0, 0, 1);
    expect_o("bp_done", 1, 0, 0, 0, 64'h0, CT + 16'd2);
`else
    step(8'h00, 0, 0, 1);
    expect_o("bp_done", 1, 0, 0, 0, 64'h0, CT + 16'd1);
`endif

    // async reset mid-block after 5 bytes
    for (int i = 0; i < 5; i++) step(8'h61 + 8'(i), 1, 0, 1);
    @(negedge Clk);
    Byte_Valid = 1'b0;
    #2 Reset_n = 1'b0;
    #1;
    expect_o("rst_mid", 1, 0, 0, 1, 64'h0, 16'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(8'h31 + 8'(i), 1, 0, 1);
      expect_o($sformatf("rst_fill%0d", i), 1, 0, 0, 0, 64'h0, 16'd0);
    end
    step(8'h00, 0, 0, 1);
    expect_o("rst_blk", 0, 1, 0, 1, 64'h3132333435363738, 16'd0);
    step(8'h00, 0, 0, 1);
    expect_o("rst_after", 1, 0, 0, 0, 64'h0, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
